// File: rtl/gtx_rx_pkg.sv
// Shared types and helpers for the GTX receive-lane link controller.
// Holds the FSM state enum, the word-class enum and the default comma pair.
package gtx_rx_pkg;

    typedef enum logic [1:0] {
        RESET    = 2'd0,
        WAIT_RDY = 2'd1,
        HUNT     = 2'd2,
        LOCKED   = 2'd3
    } gtx_rx_state_e;

    typedef enum logic [1:0] {
        WC_COMMA = 2'd0,
        WC_DATA  = 2'd1,
        WC_BAD   = 2'd2
    } word_class_e;

    localparam logic [15:0] COMMA_DEFAULT = 16'hBCBC;

    // Bits needed to hold every value 0..max_val; never narrower than 1.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/gtx_rx_word_class.sv
// Combinational classifier of one RX word (charisk + data) into COMMA, DATA or BAD.
// Mixed or partial charisk patterns are BAD, as is a K-pair that is not the comma.
module gtx_rx_word_class
    import gtx_rx_pkg::*;
#(
    parameter logic [15:0] COMMA = COMMA_DEFAULT
) (
    input  logic [1:0]  ctrl_i,
    input  logic [15:0] data_i,
    output word_class_e wclass_o
);

    always_comb begin
        wclass_o = WC_BAD;
        if (ctrl_i == 2'b00) begin
            wclass_o = WC_DATA;
        end else if (ctrl_i == 2'b11 && data_i == COMMA) begin
            wclass_o = WC_COMMA;
        end
    end

endmodule

// File: rtl/gtx_rx_link_ctrl.sv
// Bring-up and supervision of one GTX RX lane: transceiver reset, comma hunt,
// lock declaration with error-burst tolerance, and registered payload forwarding.
module gtx_rx_link_ctrl
    import gtx_rx_pkg::*;
#(
    parameter logic [15:0] COMMA      = COMMA_DEFAULT,
    parameter int          LOCK_CNT   = 4,
    parameter int          ERR_MAX    = 8,
    parameter int          TIMEOUT    = 65535,
    parameter int          RST_CYCLES = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          gtx_rst_done_i,
    input  logic [1:0]    ctrl_i,
    input  logic [15:0]   data_i,
    output logic          gtx_rst_o,
    output logic          lock_o,
    output logic [15:0]   data_o,
    output logic          data_vld_o,
    output logic [7:0]    relock_cnt_o,
    output gtx_rx_state_e state_o
);

    localparam int RST_W = cnt_w(RST_CYCLES);
    localparam int TMR_W = cnt_w(TIMEOUT);
    localparam int LCK_W = cnt_w(LOCK_CNT);
    localparam int ERR_W = cnt_w(ERR_MAX);

    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_SAT  = '1;
    localparam logic [LCK_W-1:0] LCK_LAST = LCK_W'(LOCK_CNT - 1);
    localparam logic [ERR_W-1:0] ERR_LAST = ERR_W'(ERR_MAX - 1);

    gtx_rx_state_e    state_q, state_d;
    logic             gtx_rst_q, gtx_rst_d;
    logic             lock_q, lock_d;
    logic [15:0]      data_q, data_d;
    logic             vld_q, vld_d;
    logic [7:0]       relock_q, relock_d;
    logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [LCK_W-1:0] comma_q, comma_d;
    logic [ERR_W-1:0] err_q, err_d;

    logic go_reset, go_wait, go_hunt, go_locked, relock_inc;
    word_class_e wclass;

    gtx_rx_word_class #(
        .COMMA(COMMA)
    ) u_word_class (
        .ctrl_i  (ctrl_i),
        .data_i  (data_i),
        .wclass_o(wclass)
    );

    // Each state only raises a transition flag; the entry values for the target
    // state are applied in one place below so every entry clears the timer.
    always_comb begin
        state_d    = state_q;
        gtx_rst_d  = gtx_rst_q;
        lock_d     = lock_q;
        data_d     = data_q;
        vld_d      = 1'b0;
        relock_d   = relock_q;
        rst_cnt_d  = rst_cnt_q;
        timer_d    = (timer_q == TMR_SAT) ? timer_q : timer_q + TMR_W'(1);
        comma_d    = comma_q;
        err_d      = err_q;
        go_reset   = 1'b0;
        go_wait    = 1'b0;
        go_hunt    = 1'b0;
        go_locked  = 1'b0;
        relock_inc = 1'b0;

        case (state_q)
            RESET: begin
                gtx_rst_d = 1'b1;
                if (rst_cnt_q == RST_LAST) begin
                    go_wait = 1'b1;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                end
            end
            WAIT_RDY: begin
                if (gtx_rst_done_i) begin
                    go_hunt = 1'b1;
                end else if (timer_q == TMR_LAST) begin
                    go_reset = 1'b1;
                end
            end
            HUNT: begin
                if (!gtx_rst_done_i || timer_q == TMR_LAST) begin
                    go_reset = 1'b1;
                end else if (wclass == WC_COMMA) begin
                    if (comma_q == LCK_LAST) begin
                        go_locked = 1'b1;
                    end else begin
                        comma_d = comma_q + LCK_W'(1);
                    end
                end else begin
                    comma_d = '0;
                end
            end
            LOCKED: begin
                if (!gtx_rst_done_i) begin
                    go_reset   = 1'b1;
                    relock_inc = 1'b1;
                end else begin
                    case (wclass)
                        WC_DATA: begin
                            vld_d  = 1'b1;
                            data_d = data_i;
                        end
                        WC_COMMA: begin
                            vld_d = 1'b0;
                        end
                        default: begin
                            if (err_q == ERR_LAST) begin
                                go_hunt    = 1'b1;
                                relock_inc = 1'b1;
                            end else begin
                                err_d = err_q + ERR_W'(1);
                            end
                        end
                    endcase
                end
            end
            default: begin
                go_reset = 1'b1;
            end
        endcase

        if (go_reset) begin
            state_d   = RESET;
            gtx_rst_d = 1'b1;
            rst_cnt_d = '0;
            lock_d    = 1'b0;
            vld_d     = 1'b0;
            timer_d   = '0;
        end else if (go_wait) begin
            state_d   = WAIT_RDY;
            gtx_rst_d = 1'b0;
            timer_d   = '0;
        end else if (go_hunt) begin
            state_d = HUNT;
            lock_d  = 1'b0;
            vld_d   = 1'b0;
            comma_d = '0;
            timer_d = '0;
        end else if (go_locked) begin
            state_d = LOCKED;
            lock_d  = 1'b1;
            err_d   = '0;
            timer_d = '0;
        end

        if (relock_inc && relock_q != 8'hFF) begin
            relock_d = relock_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= RESET;
            gtx_rst_q <= 1'b1;
            lock_q    <= 1'b0;
            data_q    <= '0;
            vld_q     <= 1'b0;
            relock_q  <= '0;
            rst_cnt_q <= '0;
            timer_q   <= '0;
            comma_q   <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            gtx_rst_q <= gtx_rst_d;
            lock_q    <= lock_d;
            data_q    <= data_d;
            vld_q     <= vld_d;
            relock_q  <= relock_d;
            rst_cnt_q <= rst_cnt_d;
            timer_q   <= timer_d;
            comma_q   <= comma_d;
            err_q     <= err_d;
        end
    end

    // data_o/data_vld_o is a valid-only stream: a word is delivered on every
    // cycle data_vld_o is high, there is no ready and no backpressure.
    assign gtx_rst_o    = gtx_rst_q;
    assign lock_o       = lock_q;
    assign data_o       = data_q;
    assign data_vld_o   = vld_q;
    assign relock_cnt_o = relock_q;
    assign state_o      = state_q;

endmodule
